fht_host_port: RTL

Host-side driver for the FHT core's external RAM port. It deserialises one input sample per handshake and writes it into the core's four RAM banks. It then pulses the core's start input and waits for completion. Finally it reads the four result banks and streams the transform back out one point per handshake in natural order. It sits between a serial sample source/sink and the FHT core's iWE/iDATA_x/iADDR_WR_x/iADDR_RD_x/oDATA_x/iSTART/oRDY pins.

---
 rtl/fht_host_port.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fht_host_port.sv
// fht_host_port
// -------------
// Host-side driver for the FHT core's external RAM port. It takes one
// input sample per handshake and writes it into the four core banks.
// It then strobes the core start and waits for the core to finish.
// After that it reads the four result banks back one address at a time
// and streams the frame out, one point per handshake, in natural order.
//
// Point n lives in bank n[1:0] at address n[A_BIT+1:2], for both load
// and unload. Frame length N = 4 * 2^A_BIT.
//
// Ports
//   iCLK, iRESET            clock, synchronous active-high reset
//   iS_DATA/VALID, oS_READY sample input stream (ready only while loading)
//   oM_DATA/VALID/LAST      result output stream, iM_READY from the sink
//   oFHT_WE                 one-hot bank write enable to core iWE
//   oFHT_DATA_0..3          write data to core iDATA_0..3
//   oFHT_ADDR_WR_0..3       write address to core iADDR_WR_0..3
//   oFHT_ADDR_RD_0..3       read address to core iADDR_RD_0..3
//   iFHT_DATA_0..3          read data from core oDATA_0..3 (RD_LAT later)
//   oFHT_START              one-cycle start strobe to core iSTART
//   iFHT_RDY                core ready level
module fht_host_port #(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 2,
  parameter int RD_LAT = 1
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iS_DATA,
  input  logic             iS_VALID,
  output logic             oS_READY,
  output logic [D_BIT-1:0] oM_DATA,
  output logic             oM_VALID,
  input  logic             iM_READY,
  output logic             oM_LAST,
  output logic [3:0]       oFHT_WE,
  output logic [D_BIT-1:0] oFHT_DATA_0,
  output logic [D_BIT-1:0] oFHT_DATA_1,
  output logic [D_BIT-1:0] oFHT_DATA_2,
  output logic [D_BIT-1:0] oFHT_DATA_3,
  output logic [A_BIT-1:0] oFHT_ADDR_WR_0,
  output logic [A_BIT-1:0] oFHT_ADDR_WR_1,
  output logic [A_BIT-1:0] oFHT_ADDR_WR_2,
  output logic [A_BIT-1:0] oFHT_ADDR_WR_3,
  output logic [A_BIT-1:0] oFHT_ADDR_RD_0,
  output logic [A_BIT-1:0] oFHT_ADDR_RD_1,
  output logic [A_BIT-1:0] oFHT_ADDR_RD_2,
  output logic [A_BIT-1:0] oFHT_ADDR_RD_3,
  input  logic [D_BIT-1:0] iFHT_DATA_0,
  input  logic [D_BIT-1:0] iFHT_DATA_1,
  input  logic [D_BIT-1:0] iFHT_DATA_2,
  input  logic [D_BIT-1:0] iFHT_DATA_3,
  output logic             oFHT_START,
  input  logic             iFHT_RDY
);

  localparam int CW = A_BIT + 2;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [CW-1:0]    C_LAST   = {CW{1'b1}};
  localparam logic [A_BIT-1:0] A_LAST   = {A_BIT{1'b1}};
  localparam logic [LW-1:0]    LAT_LAST = LW'(RD_LAT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] FLUSH   = 3'd2;
  localparam logic [2:0] START   = 3'd3;
  localparam logic [2:0] WAIT    = 3'd4;
  localparam logic [2:0] RD_ADDR = 3'd5;
  localparam logic [2:0] RD_WAIT = 3'd6;
  localparam logic [2:0] EMIT    = 3'd7;

  logic [2:0]       state;
  logic [CW-1:0]    load_cnt;
  logic [A_BIT-1:0] grp_cnt;
  logic [1:0]       word_cnt;
  logic [LW-1:0]    lat_cnt;
  logic             rdy_d;
  logic [3:0]       we;
  logic [A_BIT-1:0] wr_addr;
  logic [D_BIT-1:0] wr_data;
  logic [A_BIT-1:0] rd_addr;
  logic [D_BIT-1:0] rbuf [4];
  logic             s_hs;
  logic             rdy_rise;

  assign oS_READY   = (state == LOAD);
  assign s_hs       = iS_VALID & oS_READY;
  assign oFHT_START = (state == START);
  // A high level carried into WAIT leaves rdy_d high, so only a genuine
  // low-to-high transition of the core ready ends the wait.
  assign rdy_rise   = iFHT_RDY & ~rdy_d;

  // The output word is picked from the group buffer by the word counter,
  // so data and last stay frozen for as long as the sink stalls.
  assign oM_VALID = (state == EMIT);
  assign oM_DATA  = rbuf[word_cnt];
  assign oM_LAST  = (state == EMIT) && (grp_cnt == A_LAST) && (word_cnt == 2'd3);

  assign oFHT_WE        = we;
  assign oFHT_DATA_0    = wr_data;
  assign oFHT_DATA_1    = wr_data;
  assign oFHT_DATA_2    = wr_data;
  assign oFHT_DATA_3    = wr_data;
  assign oFHT_ADDR_WR_0 = wr_addr;
  assign oFHT_ADDR_WR_1 = wr_addr;
  assign oFHT_ADDR_WR_2 = wr_addr;
  assign oFHT_ADDR_WR_3 = wr_addr;
  assign oFHT_ADDR_RD_0 = rd_addr;
  assign oFHT_ADDR_RD_1 = rd_addr;
  assign oFHT_ADDR_RD_2 = rd_addr;
  assign oFHT_ADDR_RD_3 = rd_addr;

  // Frame sequencer. Writes are registered, so a sample accepted in one
  // cycle reaches the core RAM port in the next; FLUSH exists only to let
  // the final write land before the start strobe. The read address is
  // loaded on the way into RD_ADDR so it is already valid in that cycle.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= IDLE;
      load_cnt <= '0;
      grp_cnt  <= '0;
      word_cnt <= '0;
      lat_cnt  <= '0;
      rdy_d    <= 1'b1;
      we       <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_addr  <= '0;
      for (int i = 0; i < 4; i++) rbuf[i] <= '0;
    end else begin
      we    <= '0;
      rdy_d <= iFHT_RDY;
      case (state)
        IDLE: begin
          load_cnt <= '0;
          state    <= LOAD;
        end
        LOAD: begin
          if (s_hs) begin
            we       <= 4'b0001 << load_cnt[1:0];
            wr_addr  <= load_cnt[CW-1:2];
            wr_data  <= iS_DATA;
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == C_LAST) state <= FLUSH;
          end
        end
        FLUSH: state <= START;
        START: state <= WAIT;
        WAIT: begin
          if (rdy_rise) begin
            grp_cnt <= '0;
            rd_addr <= '0;
            state   <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          lat_cnt <= '0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rbuf[0]  <= iFHT_DATA_0;
            rbuf[1]  <= iFHT_DATA_1;
            rbuf[2]  <= iFHT_DATA_2;
            rbuf[3]  <= iFHT_DATA_3;
            word_cnt <= '0;
            state    <= EMIT;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        EMIT: begin
          if (iM_READY) begin
            if (word_cnt == 2'd3) begin
              word_cnt <= '0;
              if (grp_cnt == A_LAST) begin
                grp_cnt  <= '0;
                load_cnt <= '0;
                state    <= LOAD;
              end else begin
                grp_cnt <= grp_cnt + 1'b1;
                rd_addr <= grp_cnt + 1'b1;
                state   <= RD_ADDR;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
